// File: rtl/present_enc_scheduler_if.sv
// Request/response bundle between client blocks and the PRESENT-80 job scheduler.
// Valid/ready: a word moves on a rising clk edge where valid and ready are both 1; a response
// source holds its payload while valid=1 and ready=0, while requesters may withdraw before acceptance.
interface present_enc_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [64*NREQ-1:0] req_pt;
  logic [80*NREQ-1:0] req_key;
  logic               resp_valid;
  logic               resp_ready;
  logic [63:0]        resp_ct;
  logic [IDW-1:0]     resp_id;

  modport master (
    output req_valid, req_pt, req_key, resp_ready,
    input  req_ready, resp_valid, resp_ct, resp_id
  );

  modport slave (
    input  req_valid, req_pt, req_key, resp_ready,
    output req_ready, resp_valid, resp_ct, resp_id
  );
endinterface

// File: rtl/present_enc_scheduler.sv
// Round-robin scheduler sharing one iterative PRESENT-80 core among NREQ requesters;
// counts the 31 core rounds and returns the ciphertext tagged with the requester id.
module present_enc_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  present_enc_scheduler_if.slave bus,
  output logic                   core_load,
  output logic [63:0]            core_idat,
  output logic [79:0]            core_key,
  input  logic [63:0]            core_odat,
  input  logic                   core_done,
  output logic                   busy,
  output logic                   seq_err
);
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  localparam logic [4:0]     LAST_CNT = 5'd31;
  localparam logic [IDW-1:0] RR_INIT  = IDW'(NREQ - 1);

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [IDW-1:0] rr_last_q, rr_last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic [63:0]    resp_ct_q, resp_ct_d;
  logic           resp_valid_q, resp_valid_d;
  logic           seq_err_q, seq_err_d;

  logic            slot_free;
  logic            grant;
  logic [NREQ-1:0] rot;
  int              off;
  logic [IDW-1:0]  win;

  // Rotate so bit 0 is the requester just after rr_last; the lowest set bit is the winner.
  always_comb begin
    rot = NREQ'({bus.req_valid, bus.req_valid} >> (int'(rr_last_q) + 1));
    off = 0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    win = IDW'((int'(rr_last_q) + 1 + off) % NREQ);
  end

  // A grant needs the response slot to be empty or draining, since capture cannot stall.
  assign slot_free = !resp_valid_q || bus.resp_ready;
  assign grant     = (state_q == S_IDLE) && slot_free && (|bus.req_valid);

  always_comb begin
    bus.req_ready = '0;
    core_load     = 1'b0;
    core_idat     = '0;
    core_key      = '0;
    if (grant) begin
      bus.req_ready = NREQ'(1) << win;
      core_load     = 1'b1;
      core_idat     = bus.req_pt[64*int'(win) +: 64];
      core_key      = bus.req_key[80*int'(win) +: 80];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_last_d    = rr_last_q;
    id_d         = id_q;
    resp_id_d    = resp_id_q;
    resp_ct_d    = resp_ct_q;
    resp_valid_d = resp_valid_q && !bus.resp_ready;
    seq_err_d    = seq_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          rr_last_d = win;
          id_d      = win;
          cnt_d     = 5'd0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_CNT) begin
          resp_ct_d    = core_odat;
          resp_id_d    = id_q;
          resp_valid_d = 1'b1;
          state_d      = S_IDLE;
          if (!core_done) seq_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 5'd0;
      rr_last_q    <= RR_INIT;
      id_q         <= '0;
      resp_id_q    <= '0;
      resp_ct_q    <= '0;
      resp_valid_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_last_q    <= rr_last_d;
      id_q         <= id_d;
      resp_id_q    <= resp_id_d;
      resp_ct_q    <= resp_ct_d;
      resp_valid_q <= resp_valid_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_ct    = resp_ct_q;
  assign bus.resp_id    = resp_id_q;
  assign busy           = (state_q == S_RUN);
  assign seq_err        = seq_err_q;
endmodule

// File: tb/tb_present_enc_scheduler.sv
// Bench for present_enc_scheduler: a PRESENT-80 core stand-in, known-answer table, corner
// sequences and randomized traffic checked against a job-level reference model.
module tb_present_enc_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 33;

  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  present_enc_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  logic        core_load;
  logic [63:0] core_idat;
  logic [79:0] core_key;
  logic [63:0] core_odat;
  logic        core_done;
  logic        busy;
  logic        seq_err;

  present_enc_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .core_load(core_load), .core_idat(core_idat), .core_key(core_key),
    .core_odat(core_odat), .core_done(core_done),
    .busy(busy), .seq_err(seq_err)
  );

  // ---------------- PRESENT-80 arithmetic ----------------
  function automatic logic [63:0] round_fn(input logic [63:0] s, input logic [63:0] rk);
    logic [63:0] t;
    logic [63:0] p;
    t = s ^ rk;
    for (int n = 0; n < 16; n++) t[4*n +: 4] = SBOX[t[4*n +: 4]];
    p = '0;
    for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (16*i) % 63] = t[i];
    return p;
  endfunction

  function automatic logic [79:0] key_next(input logic [79:0] k, input int rc);
    logic [79:0] r;
    logic [4:0]  c;
    r = {k[18:0], k[79:19]};
    r[79:76] = SBOX[r[79:76]];
    c = 5'(rc);
    r[19:15] = r[19:15] ^ c;
    return r;
  endfunction

  function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int i = 1; i <= 31; i++) begin
      s = round_fn(s, k[79:16]);
      k = key_next(k, i);
    end
    return s ^ k[79:16];
  endfunction

  // Core stand-in: load edge -> round 1, 31 more edges finish, result visible at round 32.
  logic [63:0] c_st = '0;
  logic [79:0] c_k = '0;
  int          c_rnd = 0;
  logic        force_done_low = 1'b0;
  always @(posedge clk) begin
    if (core_load) begin
      c_st  <= core_idat;
      c_k   <= core_key;
      c_rnd <= 1;
    end else if (c_rnd >= 1 && c_rnd <= 31) begin
      c_st  <= round_fn(c_st, c_k[79:16]);
      c_k   <= key_next(c_k, c_rnd);
      c_rnd <= c_rnd + 1;
    end
  end
  assign core_odat = c_st ^ c_k[79:16];
  assign core_done = (c_rnd == 32) && !force_done_low;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [IDW+63:0] exp_q[$];
  int          due_q[$];
  int          g_id[$];
  int          g_cyc[$];
  logic [63:0] r_ct[$];
  int          r_id[$];
  int          r_cyc[$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  int          m_last = NREQ - 1;
  int          next_free = 0;
  int          last_g = -10;
  logic        m_seq_err = 1'b0;
  logic        prev_rv = 1'b0;
  logic        prev_rr = 1'b0;
  logic [63:0] prev_ct = '0;
  logic [IDW-1:0] prev_id = '0;

  always @(negedge clk) begin : mon
    logic [NREQ-1:0] exp_rdy;
    int              w;
    logic            seq_next;
    logic [IDW+63:0] e;
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      m_last    = NREQ - 1;
      next_free = cyc + 1;
      last_g    = cyc;
      m_seq_err = 1'b0;
      prev_rv   = 1'b0;
      prev_rr   = 1'b0;
    end else begin
      seq_next = m_seq_err;
      exp_rdy  = '0;
      w        = -1;
      if (cyc >= next_free && (!bus.resp_valid || bus.resp_ready) && (|bus.req_valid)) begin
        w       = rr_pick(m_last, bus.req_valid);
        exp_rdy = NREQ'(1) << w;
      end
      if (bus.req_valid != '0 || bus.req_ready != '0) check("req_ready", bus.req_ready, exp_rdy);
      check("core_load", core_load, |exp_rdy);
      check("busy", busy, (cyc > last_g) && (cyc < next_free));
      check("seq_err", seq_err, m_seq_err);
      if (w >= 0) begin
        check("core_idat", core_idat, bus.req_pt[64*w +: 64]);
        check("core_key", core_key, bus.req_key[80*w +: 80]);
        exp_q.push_back({IDW'(w), present_enc(bus.req_pt[64*w +: 64], bus.req_key[80*w +: 80])});
        due_q.push_back(cyc + LAT);
        g_id.push_back(w);
        g_cyc.push_back(cyc);
        m_last    = w;
        last_g    = cyc;
        next_free = cyc + LAT;
      end else begin
        check("core_idle_data", (core_idat != '0) || (core_key != '0), 0);
      end
      if (due_q.size() > 0 && cyc == due_q[0] - 1 && !core_done) seq_next = 1'b1;
      if (bus.resp_valid && !prev_rv) begin
        if (due_q.size() == 0) check("resp_spurious", 1, 0);
        else begin
          check("resp_latency", cyc, due_q[0]);
          void'(due_q.pop_front());
        end
      end
      if (due_q.size() > 0 && cyc > due_q[0]) begin
        check("resp_missing", cyc, due_q[0]);
        void'(due_q.pop_front());
      end
      if (prev_rv && !prev_rr) begin
        check("resp_hold_valid", bus.resp_valid, 1);
        check("resp_hold_ct", bus.resp_ct, prev_ct);
        check("resp_hold_id", bus.resp_id, prev_id);
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("resp_ct", bus.resp_ct, e[63:0]);
          check("resp_id", bus.resp_id, e[IDW+63:64]);
        end
        r_ct.push_back(bus.resp_ct);
        r_id.push_back(int'(bus.resp_id));
        r_cyc.push_back(cyc);
      end
      prev_rv   = bus.resp_valid;
      prev_rr   = bus.resp_ready;
      prev_ct   = bus.resp_ct;
      prev_id   = bus.resp_id;
      m_seq_err = seq_next;
    end
  end

  // ---------------- driver tasks ----------------
  logic [NREQ-1:0] sticky = '0;
  logic            s_rv = 1'b0;

  task automatic tick();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc  = bus.req_valid & bus.req_ready;
    s_rv = bus.resp_valid;
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~(acc & ~sticky);
  endtask

  task automatic raise(input int id, input logic [63:0] pt, input logic [79:0] key);
    bus.req_pt[64*id +: 64]  = pt;
    bus.req_key[80*id +: 80] = key;
    bus.req_valid[id]        = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bus.resp_ready = 1'b1;
    while (((bus.req_valid & ~sticky) != '0 || exp_q.size() != 0 || bus.resp_valid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", n >= budget, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int g0, input int budget);
    int n;
    n = 0;
    while (g_cyc.size() == g0 && n < budget) begin
      tick();
      n++;
    end
    check("grant_timeout", g_cyc.size() - g0, 1);
  endtask

  function automatic logic [79:0] rand_key();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  typedef struct {
    int          id;
    logic [63:0] pt;
    logic [79:0] key;
    logic [63:0] ct;
  } vec_t;
  vec_t vt[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int r0;
    int n;
    bus.req_valid  = '0;
    bus.req_pt     = '0;
    bus.req_key    = '0;
    bus.resp_ready = 1'b1;

    vt[0] = '{0, 64'h0, 80'h0, 64'h5579c1387b228445};
    vt[1] = '{1, 64'h0, {80{1'b1}}, 64'he72c46c0f5945049};
    vt[2] = '{2, {64{1'b1}}, 80'h0, 64'ha112ffc72f68417b};
    vt[3] = '{3, {64{1'b1}}, {80{1'b1}}, 64'h3333dcd3213210d2};
    vt[4] = '{2, 64'h0, 80'h0, 64'h5579c1387b228445};
    vt[5] = '{1, {64{1'b1}}, {80{1'b1}}, 64'h3333dcd3213210d2};

    // reset state
    do_reset();
    @(negedge clk);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_ct", bus.resp_ct, 0);
    check("rst_resp_id", bus.resp_id, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_core_load", core_load, 0);
    check("rst_core_idat", core_idat, 0);
    check("rst_core_key", core_key, 0);
    @(posedge clk);
    #1;

    // known-answer table, one job at a time
    for (int i = 0; i < 6; i++) begin
      g0 = g_cyc.size();
      r0 = r_cyc.size();
      raise(vt[i].id, vt[i].pt, vt[i].key);
      drain(100);
      check("kat_count", r_cyc.size() - r0, 1);
      if (r_cyc.size() == r0 + 1 && g_cyc.size() == g0 + 1) begin
        check("kat_ct", r_ct[r0], vt[i].ct);
        check("kat_id", r_id[r0], vt[i].id);
        check("kat_latency", r_cyc[r0] - g_cyc[g0], LAT);
      end
    end

    // four requesters at once after reset: served 0,1,2,3
    do_reset();
    g0 = g_cyc.size();
    r0 = r_cyc.size();
    for (int i = 0; i < 4; i++) raise(i, vt[i].pt, vt[i].key);
    drain(300);
    check("all4_count", r_cyc.size() - r0, 4);
    if (r_cyc.size() == r0 + 4 && g_cyc.size() == g0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        check("all4_order", g_id[g0+i], i);
        check("all4_ct", r_ct[r0+i], vt[i].ct);
      end
    end

    // full slot held 100 cycles blocks a pending job; release grants in the handshake cycle
    bus.resp_ready = 1'b0;
    r0 = r_cyc.size();
    raise(0, 64'h0, 80'h0);
    n = 0;
    s_rv = 1'b0;
    while (!s_rv && n < 60) begin
      tick();
      n++;
    end
    check("hold_result_timeout", s_rv, 1);
    g0 = g_cyc.size();
    raise(1, {$urandom, $urandom}, rand_key());
    repeat (100) tick();
    check("hold_no_grant", g_cyc.size() - g0, 0);
    check("hold_resp_valid", bus.resp_valid, 1);
    check("hold_resp_ct", bus.resp_ct, 64'h5579c1387b228445);
    bus.resp_ready = 1'b1;
    tick();
    check("release_grant", g_cyc.size() - g0, 1);
    if (g_cyc.size() > g0 && r_cyc.size() > r0) begin
      check("release_grant_id", g_id[g0], 1);
      check("release_same_cycle", g_cyc[g0], r_cyc[r0]);
    end
    drain(100);

    // req0 and req2 held valid: grants alternate with 33-cycle spacing
    do_reset();
    g0 = g_cyc.size();
    sticky = 4'b0101;
    raise(0, {$urandom, $urandom}, rand_key());
    raise(2, {$urandom, $urandom}, rand_key());
    n = 0;
    while (g_cyc.size() < g0 + 4 && n < 300) begin
      tick();
      n++;
    end
    check("alt_count", g_cyc.size() - g0 >= 4, 1);
    if (g_cyc.size() >= g0 + 4) begin
      for (int k = 0; k < 4; k++) check("alt_id", g_id[g0+k], (k % 2 == 0) ? 0 : 2);
      for (int k = 1; k < 4; k++) check("alt_gap", g_cyc[g0+k] - g_cyc[g0+k-1], LAT);
    end
    sticky = '0;
    bus.req_valid = '0;
    drain(100);

    // reset at cnt==15 discards the job
    g0 = g_cyc.size();
    raise(1, {$urandom, $urandom}, rand_key());
    wait_grant(g0, 50);
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_resp_valid", bus.resp_valid, 0);
    check("midrst_resp_ct", bus.resp_ct, 0);
    check("midrst_resp_id", bus.resp_id, 0);
    check("midrst_req_ready", bus.req_ready, 0);
    check("midrst_core_load", core_load, 0);
    check("midrst_seq_err", seq_err, 0);
    @(posedge clk);
    #1;
    r0 = r_cyc.size();
    repeat (40) tick();
    check("midrst_no_resp", r_cyc.size() - r0, 0);
    raise(3, 64'h0, 80'h0);
    drain(100);
    check("midrst_next_count", r_cyc.size() - r0, 1);
    if (r_cyc.size() == r0 + 1) begin
      check("midrst_next_ct", r_ct[r0], 64'h5579c1387b228445);
      check("midrst_next_id", r_id[r0], 3);
    end

    // core_done low at capture sets sticky seq_err
    g0 = g_cyc.size();
    raise(2, {$urandom, $urandom}, rand_key());
    wait_grant(g0, 50);
    repeat (31) tick();
    force_done_low = 1'b1;
    tick();
    force_done_low = 1'b0;
    check("seqerr_set", seq_err, 1);
    drain(50);
    repeat (5) tick();
    check("seqerr_sticky", seq_err, 1);
    do_reset();
    check("seqerr_cleared", seq_err, 0);

    // randomized traffic with withdrawals and response backpressure
    for (int c = 0; c < 3000; c++) begin
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 15) == 0) raise(i, {$urandom, $urandom}, rand_key());
        else if (bus.req_valid[i] && $urandom_range(0, 31) == 0) bus.req_valid[i] = 1'b0;
      end
      tick();
    end
    bus.req_valid = '0;
    drain(200);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
